// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer: FSM state codes and shift op codes.
package shift_sequencer_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_SHIFT = SHIFT,
    ST_DONE  = DONE
  } state_t;

  localparam logic [1:0] PASS = 2'b00;
  localparam logic [1:0] LSL  = 2'b01;
  localparam logic [1:0] LSR  = 2'b10;
  localparam logic [1:0] ASR  = 2'b11;

endpackage

// File: rtl/shift_sequencer_step.sv
// Single-step 16-bit shifter: moves the operand by exactly one bit position.
module shift_sequencer_step
  import shift_sequencer_pkg::*;
(
  input  logic [15:0] in,
  input  logic [1:0]  shift,
  output logic [15:0] sout
);

  logic signed [15:0] in_s;

  assign in_s = in;

  // One-bit move; the bit shifted out is dropped, the vacated bit is filled per op
  always_comb begin
    sout = in;
    case (shift)
      PASS:    sout = in;
      LSL:     sout = {in[14:0], 1'b0};
      LSR:     sout = {1'b0, in[15:1]};
      ASR:     sout = in_s >>> 1;
      default: sout = in;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: applies amt single-bit steps of the captured op to the
// captured operand, one step per clock, and pulses done with the result.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      in,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [15:0]      out
);

  state_t           state, state_nxt;
  logic [15:0]      data, data_nxt;
  logic [1:0]       op_r, op_nxt;
  logic [AMT_W-1:0] count, count_nxt;
  logic [15:0]      step_out;

  shift_sequencer_step u_step (
    .in    (data),
    .shift (op_r),
    .sout  (step_out)
  );

  // State and datapath registers; reset clears everything so out reads zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      data  <= 16'h0000;
      op_r  <= PASS;
      count <= '0;
    end else begin
      state <= state_nxt;
      data  <= data_nxt;
      op_r  <= op_nxt;
      count <= count_nxt;
    end
  end

  // Next state: accept in IDLE/DONE, step in SHIFT, leave on the final step
  always_comb begin
    state_nxt = state;
    data_nxt  = data;
    op_nxt    = op_r;
    count_nxt = count;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          data_nxt  = in;
          op_nxt    = op;
          count_nxt = amt;
          if (amt == '0 || op == PASS) state_nxt = ST_DONE;
          else                         state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        data_nxt = step_out;
        // count is at least 1 here, so the decrement cannot wrap
        count_nxt = count - AMT_W'(1);
        if (count == AMT_W'(1)) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_SHIFT);
  assign done = (state == ST_DONE);
  assign out  = data;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomised and directed bench for shift_sequencer against a behavioural model.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] in = 16'h0000;
  logic [1:0]  op = 2'b00;
  logic [3:0]  amt = 4'd0;
  logic        busy, done;
  logic [15:0] out;

  int n_checks = 0;
  int n_errors = 0;

  shift_sequencer #(.AMT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in    (in),
    .op    (op),
    .amt   (amt),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Whole-operation result: n bit moves computed directly with shift operators
  function automatic logic [15:0] ref_shift(input logic [15:0] v, input logic [1:0] o, input int n);
    logic signed [15:0] vs;
    vs = v;
    case (o)
      2'b01:   return v << n;
      2'b10:   return v >> n;
      2'b11:   return 16'(vs >>> n);
      default: return v;
    endcase
  endfunction

  // Reference model: phase 0 idle, 1 shifting, 2 done; out tracks partial result
  int          m_phase = 0;
  int          m_steps = 0;
  int          m_amt = 0;
  logic [15:0] m_in = 16'h0;
  logic [1:0]  m_op = 2'b0;
  logic [15:0] m_out = 16'h0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase <= 0;
      m_steps <= 0;
      m_out   <= 16'h0;
    end else if (m_phase == 1) begin
      m_steps <= m_steps + 1;
      m_out   <= ref_shift(m_in, m_op, m_steps + 1);
      if (m_steps + 1 == m_amt) m_phase <= 2;
    end else if (start) begin
      m_in    <= in;
      m_op    <= op;
      m_amt   <= int'(amt);
      m_steps <= 0;
      m_out   <= in;
      m_phase <= (amt == 4'd0 || op == 2'b00) ? 2 : 1;
    end else begin
      m_phase <= 0;
    end
  end

  logic mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_busy", busy, (m_phase == 1));
      check("mon_done", done, (m_phase == 2));
      check("mon_out", out, m_out);
    end
  end

  // Issue one operation from idle and measure latency/busy cycles to done
  task automatic run_op(input logic [15:0] v, input logic [1:0] o, input logic [3:0] a,
                        input logic [15:0] exp, input string tag);
    int lat, bsy, exp_lat;
    exp_lat = (o == 2'b00 || a == 4'd0) ? 0 : int'(a);
    @(negedge clk);
    start = 1'b1; in = v; op = o; amt = a;
    @(negedge clk);
    start = 1'b0;
    lat = 0; bsy = 0;
    while (!done && lat < 40) begin
      if (busy) bsy++;
      lat++;
      @(negedge clk);
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busycyc"}, bsy, exp_lat);
    check({tag, "_out"}, out, exp);
    check({tag, "_nobusy"}, busy, 1'b0);
  endtask

  initial begin
    int lat, dones;
    logic [15:0] rv;
    logic [1:0]  ro;
    logic [3:0]  ra;

    #1 reset = 1'b1;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out", out, 16'h0000);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_op(16'h0001, 2'b01, 4'd15, 16'h8000, "lsl15");
    run_op(16'h8000, 2'b11, 4'd15, 16'hFFFF, "asr15");
    run_op(16'h8000, 2'b10, 4'd15, 16'h0001, "lsr15");
    run_op(16'hA5A5, 2'b01, 4'd0,  16'hA5A5, "amt0");
    run_op(16'hA5A5, 2'b00, 4'd7,  16'hA5A5, "pass7");

    // Start pulse during SHIFT must be dropped, not queued
    @(negedge clk);
    start = 1'b1; in = 16'h000F; op = 2'b01; amt = 4'd4;
    @(negedge clk);
    in = 16'hFFFF; op = 2'b01; amt = 4'd1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    check("ign_done", done, 1'b1);
    check("ign_lat", lat, 4);
    check("ign_out", out, 16'h00F0);
    @(negedge clk);
    check("ign_noqueue_busy", busy, 1'b0);
    check("ign_noqueue_done", done, 1'b0);

    // Back-to-back: start held through DONE
    @(negedge clk);
    start = 1'b1; in = 16'h0003; op = 2'b01; amt = 4'd2;
    lat = 0;
    @(negedge clk);
    while (!done && lat < 40) begin
      lat++;
      @(negedge clk);
    end
    check("b2b_first_done", done, 1'b1);
    check("b2b_first_out", out, 16'h000C);
    in = 16'h1234; op = 2'b10; amt = 4'd1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_mid_done", done, 1'b0);
    check("b2b_mid_busy", busy, 1'b1);
    @(negedge clk);
    check("b2b_second_done", done, 1'b1);
    check("b2b_second_out", out, 16'h091A);

    // Reset during the third step of a 9-step shift aborts without done
    @(negedge clk);
    start = 1'b1; in = 16'h0F0F; op = 2'b01; amt = 4'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    start = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_out", out, 16'h0000);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("mid_rst_no_done", dones, 0);

    // Random operations with occasional idle gaps
    for (int k = 0; k < 40; k++) begin
      rv = 16'($urandom);
      ro = 2'($urandom_range(0, 3));
      ra = 4'($urandom_range(0, 15));
      run_op(rv, ro, ra, ref_shift(rv, ro, int'(ra)), "rnd");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
